// File: rtl/hall_pattern_generator.sv
// BLDC Hall sensor stand-in: steps through a 120/60-degree Hall table with a
// ramping step period, optional one-step invalid-code fault and a code-change strobe.
module hall_pattern_generator #(
  parameter int PERIOD_WIDTH = 32,
  parameter int STROBE_WIDTH = 16,
  parameter int START_PERIOD = 1000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable_sim,
  input  logic                    sim_direction,
  input  logic                    spacing_60,
  input  logic [PERIOD_WIDTH-1:0] target_period,
  input  logic [PERIOD_WIDTH-1:0] ramp_step,
  input  logic [STROBE_WIDTH-1:0] strobe_pulse_duration,
  input  logic                    fault_inject,
  output logic [2:0]              simulated_hall,
  output logic                    hall_sample_strobe,
  output logic                    at_speed,
  output logic [15:0]             erev_count,
  output logic [2:0]              step_index
);
  localparam int PW = PERIOD_WIDTH;
  localparam int SW = STROBE_WIDTH;
  localparam logic [PW-1:0] START = PW'(START_PERIOD);
  localparam logic [PW-1:0] MIN_P = PW'(2);

  typedef enum logic {IDLE, RUN} state_e;

  function automatic logic [2:0] code_of(input logic sp60, input logic [2:0] idx);
    logic [2:0] c;
    c = 3'b000;
    if (!sp60) begin
      case (idx)
        3'd0: c = 3'b001;
        3'd1: c = 3'b011;
        3'd2: c = 3'b010;
        3'd3: c = 3'b110;
        3'd4: c = 3'b100;
        3'd5: c = 3'b101;
        default: c = 3'b000;
      endcase
    end else begin
      case (idx)
        3'd0: c = 3'b000;
        3'd1: c = 3'b001;
        3'd2: c = 3'b011;
        3'd3: c = 3'b111;
        3'd4: c = 3'b110;
        3'd5: c = 3'b100;
        default: c = 3'b000;
      endcase
    end
    return c;
  endfunction

  state_e          state_q, state_d;
  logic [2:0]      hall_q, hall_d, idx_q, idx_d;
  logic            strobe_q, strobe_d, at_q, at_d, fault_q, fault_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [15:0]     erev_q, erev_d;
  logic [PW-1:0]   period_q, period_d, timer_q, timer_d;

  logic [PW-1:0]   t_clamp, ramp_period;
  logic [PW:0]     sum_w;
  logic [2:0]      next_idx;
  logic            idx_wrap, boundary;
  logic [SW-1:0]   dur_m1;

  assign t_clamp  = (target_period < MIN_P) ? MIN_P : target_period;
  assign boundary = (timer_q == period_q - 1'b1);
  assign sum_w    = {1'b0, period_q} + {1'b0, ramp_step};
  assign next_idx = sim_direction ? ((idx_q == 3'd0) ? 3'd5 : idx_q - 3'd1)
                                  : ((idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1);
  assign idx_wrap = sim_direction ? (idx_q == 3'd0) : (idx_q == 3'd5);
  // scnt counts the high cycles still owed after the current one
  assign dur_m1   = (strobe_pulse_duration == '0) ? '0 : strobe_pulse_duration - 1'b1;

  // Saturating ramp toward the clamped target; the subtract path compares
  // the gap first so it can never underflow.
  always_comb begin
    ramp_period = t_clamp;
    if (ramp_step != '0) begin
      if (period_q > t_clamp)
        ramp_period = ((period_q - t_clamp) <= ramp_step) ? t_clamp : period_q - ramp_step;
      else if (period_q < t_clamp)
        ramp_period = (sum_w > {1'b0, t_clamp}) ? t_clamp : sum_w[PW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable_sim)  state_d = RUN;
      RUN:  if (!enable_sim) state_d = IDLE;
    endcase
  end

  always_comb begin
    hall_d   = hall_q;
    idx_d    = idx_q;
    erev_d   = erev_q;
    timer_d  = timer_q;
    period_d = period_q;
    strobe_d = 1'b0;
    scnt_d   = '0;
    fault_d  = fault_q | fault_inject;
    unique case (state_q)
      IDLE: begin
        timer_d  = '0;
        period_d = START;
        if (enable_sim) begin
          hall_d   = code_of(spacing_60, idx_q);
          strobe_d = (strobe_pulse_duration != '0);
          scnt_d   = dur_m1;
        end
      end
      RUN: begin
        if (!enable_sim) begin
          timer_d  = '0;
          period_d = START;
        end else if (boundary) begin
          timer_d  = '0;
          idx_d    = next_idx;
          if (idx_wrap) erev_d = erev_q + 16'd1;
          hall_d   = fault_q ? (spacing_60 ? 3'b010 : 3'b000) : code_of(spacing_60, next_idx);
          fault_d  = fault_inject;
          period_d = ramp_period;
          strobe_d = (strobe_pulse_duration != '0);
          scnt_d   = dur_m1;
        end else begin
          timer_d  = timer_q + 1'b1;
          strobe_d = strobe_q && (scnt_q != '0);
          scnt_d   = (scnt_q != '0) ? scnt_q - 1'b1 : '0;
        end
      end
    endcase
    at_d = (state_d == RUN) && (period_d == t_clamp);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hall_q   <= 3'b000;
      idx_q    <= 3'd0;
      erev_q   <= 16'd0;
      timer_q  <= '0;
      period_q <= START;
      strobe_q <= 1'b0;
      scnt_q   <= '0;
      fault_q  <= 1'b0;
      at_q     <= 1'b0;
    end else begin
      hall_q   <= hall_d;
      idx_q    <= idx_d;
      erev_q   <= erev_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      strobe_q <= strobe_d;
      scnt_q   <= scnt_d;
      fault_q  <= fault_d;
      at_q     <= at_d;
    end
  end

  assign simulated_hall     = hall_q;
  assign hall_sample_strobe = strobe_q;
  assign at_speed           = at_q;
  assign erev_count         = erev_q;
  assign step_index         = idx_q;
endmodule

// File: tb/tb_hall_pattern_generator.sv
// Bench for hall_pattern_generator: directed phase table, strobe/reset sequences,
// and randomized traffic compared each cycle against a step-level reference model.
module tb_hall_pattern_generator;
  localparam int PW = 16;
  localparam int SW = 8;
  localparam int SP = 10;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          en = 1'b0, dir = 1'b0, sp = 1'b0, fi = 1'b0;
  logic [PW-1:0] tgt = 16'd10, rmp = 16'd0;
  logic [SW-1:0] dur = 8'd3;
  logic [2:0]    hall, idx;
  logic          strobe, at;
  logic [15:0]   erev;

  hall_pattern_generator #(.PERIOD_WIDTH(PW), .STROBE_WIDTH(SW), .START_PERIOD(SP)) dut (
    .clk(clk), .reset_n(reset_n), .enable_sim(en), .sim_direction(dir), .spacing_60(sp),
    .target_period(tgt), .ramp_step(rmp), .strobe_pulse_duration(dur), .fault_inject(fi),
    .simulated_hall(hall), .hall_sample_strobe(strobe), .at_speed(at),
    .erev_count(erev), .step_index(idx));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int m_run, m_idx, m_hall, m_sleft, m_at, m_erev, m_per, m_tmr, m_fault;
  int t120[6] = '{1, 3, 2, 6, 4, 5};
  int t60[6]  = '{0, 1, 3, 7, 6, 4};

  typedef struct {
    string nm;
    bit en, dir, sp, fi;
    int tgt, rmp, dur, n;
    int hall, idx, erev, at;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_idx = 0; m_hall = 0; m_sleft = 0; m_at = 0;
    m_erev = 0; m_per = SP; m_tmr = 0; m_fault = 0;
  endtask

  // Step-level reference: each code lasts m_per cycles, strobe owes m_sleft cycles.
  task automatic model_edge();
    int T, r;
    if (!reset_n) return;
    T = (int'(tgt) < 2) ? 2 : int'(tgt);
    r = int'(rmp);
    if (m_run == 0) begin
      if (en) begin
        m_run = 1; m_hall = sp ? t60[m_idx] : t120[m_idx]; m_sleft = int'(dur);
      end else m_sleft = 0;
      m_tmr = 0; m_per = SP; if (fi) m_fault = 1;
    end else if (!en) begin
      m_run = 0; m_sleft = 0; m_tmr = 0; m_per = SP; if (fi) m_fault = 1;
    end else if (m_tmr == m_per - 1) begin
      if (dir) begin
        if (m_idx == 0) m_erev = (m_erev + 1) % 65536;
        m_idx = (m_idx + 5) % 6;
      end else begin
        if (m_idx == 5) m_erev = (m_erev + 1) % 65536;
        m_idx = (m_idx + 1) % 6;
      end
      m_hall  = m_fault ? (sp ? 2 : 0) : (sp ? t60[m_idx] : t120[m_idx]);
      m_fault = fi;
      if (r == 0)          m_per = T;
      else if (m_per > T)  m_per = (m_per - r < T) ? T : m_per - r;
      else if (m_per < T)  m_per = (m_per + r > T) ? T : m_per + r;
      m_sleft = int'(dur); m_tmr = 0;
    end else begin
      m_tmr++;
      if (m_sleft > 0) m_sleft--;
      if (fi) m_fault = 1;
    end
    m_at = (m_run == 1 && m_per == T) ? 1 : 0;
  endtask

  task automatic check_all(input string tag);
    int act, exp;
    act = int'({hall, strobe, at, erev, idx});
    exp = (m_hall << 21) | ((m_sleft > 0 ? 1 : 0) << 20) | (m_at << 19) | (m_erev << 3) | m_idx;
    chk({tag, ":model"}, act, exp);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int hi;
    model_reset();
    @(negedge clk);
    chk("reset_hall", int'(hall), 0);
    chk("reset_strobe", int'(strobe), 0);
    chk("reset_at", int'(at), 0);
    chk("reset_erev", int'(erev), 0);
    chk("reset_idx", int'(idx), 0);
    reset_n = 1'b1;

    v.push_back('{"fwd120",     1,0,0,0, 10,0,3,61, 1,0,1,1});
    v.push_back('{"pre_rev",    1,0,0,0, 10,0,3, 4, 1,0,1,1});
    v.push_back('{"rev60_first",1,1,1,0,  8,0,3, 6, 4,5,2,1});
    v.push_back('{"rev60_idx4", 1,1,1,0,  8,0,15,8, 6,4,2,1});
    v.push_back('{"rev60_idx3", 1,1,1,0,  8,0,0, 8, 7,3,2,1});
    v.push_back('{"fwd120_idx4",1,0,0,0,  8,0,3, 8, 4,4,2,1});
    v.push_back('{"to_idx2",    1,0,0,0,  8,0,3,32, 2,2,3,1});
    v.push_back('{"fault_pulse",1,0,0,1,  8,0,3, 1, 2,2,3,1});
    v.push_back('{"fault_code", 1,0,0,0,  8,0,3, 7, 0,3,3,1});
    v.push_back('{"after_fault",1,0,0,0,  8,0,3, 8, 4,4,3,1});
    v.push_back('{"ramp_up1",   1,0,0,0, 20,5,3, 8, 5,5,3,0});
    v.push_back('{"ramp_up2",   1,0,0,0, 20,5,3,13, 1,0,4,0});
    v.push_back('{"ramp_up3",   1,0,0,0, 20,5,3,18, 3,1,4,1});
    v.push_back('{"at_target",  1,0,0,0, 20,5,3,20, 2,2,4,1});
    v.push_back('{"clamp_min",  1,0,0,0,  1,0,3,20, 6,3,4,1});
    v.push_back('{"period2",    1,0,0,0,  1,0,1, 2, 4,4,4,1});
    v.push_back('{"ramp_up_b",  1,0,0,0, 12,4,3, 2, 5,5,4,0});
    v.push_back('{"ramp_up_c",  1,0,0,0, 12,4,3, 6, 1,0,5,0});
    v.push_back('{"ramp_up_d",  1,0,0,0, 12,4,3,10, 3,1,5,1});
    v.push_back('{"ramp_dn1",   1,0,0,0,  3,4,3,12, 2,2,5,0});
    v.push_back('{"ramp_dn2",   1,0,0,0,  3,4,3, 8, 6,3,5,0});
    v.push_back('{"ramp_dn3",   1,0,0,0,  3,4,3, 4, 4,4,5,1});
    v.push_back('{"disable",    0,0,0,0, 10,0,3, 1, 4,4,5,0});
    v.push_back('{"idle_hold",  0,0,0,0, 10,0,3, 5, 4,4,5,0});
    v.push_back('{"reenable",   1,0,0,0, 10,0,3, 1, 4,4,5,1});
    v.push_back('{"full_start", 1,0,0,0, 10,0,3,10, 5,5,5,1});

    foreach (v[k]) begin
      en = v[k].en; dir = v[k].dir; sp = v[k].sp; fi = v[k].fi;
      tgt = PW'(v[k].tgt); rmp = PW'(v[k].rmp); dur = SW'(v[k].dur);
      for (int c = 0; c < v[k].n; c++) tick(v[k].nm);
      fi = 1'b0;
      chk({v[k].nm, ":hall"}, int'(hall), v[k].hall);
      chk({v[k].nm, ":idx"},  int'(idx),  v[k].idx);
      chk({v[k].nm, ":erev"}, int'(erev), v[k].erev);
      chk({v[k].nm, ":at"},   int'(at),   v[k].at);
    end

    // Strobe width over one 10-cycle step: 3 cycles, then continuous, then none.
    hi = 0;
    for (int c = 0; c < 10; c++) begin tick("strobe3"); hi += int'(strobe); end
    chk("strobe3_high", hi, 3);
    dur = 8'd15;
    for (int c = 0; c < 10; c++) tick("strobe15_warm");
    hi = 0;
    for (int c = 0; c < 10; c++) begin tick("strobe15"); hi += int'(strobe); end
    chk("strobe15_high", hi, 10);
    dur = 8'd0;
    for (int c = 0; c < 10; c++) tick("strobe0_warm");
    hi = 0;
    for (int c = 0; c < 10; c++) begin tick("strobe0"); hi += int'(strobe); end
    chk("strobe0_high", hi, 0);

    // Asynchronous reset mid-step, between clock edges.
    dur = 8'd3;
    for (int c = 0; c < 4; c++) tick("pre_reset");
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_hall", int'(hall), 0);
    chk("async_rst_idx", int'(idx), 0);
    chk("async_rst_erev", int'(erev), 0);
    chk("async_rst_strobe", int'(strobe), 0);
    model_reset();
    tick("in_reset");
    reset_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(99) < 97);
      if ($urandom_range(99) < 5) dir = $urandom_range(1);
      if ($urandom_range(99) < 5) sp = $urandom_range(1);
      if ($urandom_range(99) < 4) begin
        tgt = PW'($urandom_range(14));
        rmp = PW'($urandom_range(6));
        dur = SW'($urandom_range(12));
      end
      fi = ($urandom_range(99) < 3);
      tick("random");
    end
    fi = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hall_pattern_generator.md
Name: hall_pattern_generator

Overview:
Parametrised successor to the single-speed Hall sensor simulator. It generates 3-bit BLDC Hall codes in either 120° or 60° sensor spacing, forward or reverse. The step period ramps linearly toward a programmable target, and single-step invalid-code fault injection is supported. It drives commutation logic and hall-decoder benches in place of a real motor, and provides a strobe, an electrical revolution count and an at-speed flag for logic-analyser and scoreboard use.

Parameters:
PERIOD_WIDTH, 32, width of period/timer datapath in clock cycles
STROBE_WIDTH, 16, width of strobe pulse duration
START_PERIOD, 1000000, step period loaded at every IDLE->RUN entry; must be >= 2

Ports:
clk  in  1  main clock
reset_n  in  1  asynchronous active-low reset
enable_sim  in  1  level; high = run, low = idle/hold
sim_direction  in  1  0 forward, 1 reverse; sampled at step boundaries
spacing_60  in  1  0 = 120° table, 1 = 60° table; sampled at step boundaries
target_period  in  PERIOD_WIDTH  final step period in cycles; values < 2 treated as 2
ramp_step  in  PERIOD_WIDTH  period change per step; 0 = jump to target immediately
strobe_pulse_duration  in  STROBE_WIDTH  strobe high time in cycles; 0 = no strobe
fault_inject  in  1  single-cycle request: next step outputs an invalid code
simulated_hall  out  3  registered Hall code
hall_sample_strobe  out  1  registered strobe, asserted on each code change
at_speed  out  1  high in RUN when current period equals clamped target
erev_count  out  16  electrical revolution counter, wraps
step_index  out  3  current table index 0..5

Behaviour:
- Reset, asynchronous: state IDLE; simulated_hall=000; strobe=0; at_speed=0; erev_count=0; step_index=0; current_period=START_PERIOD; timer=0; fault_pending=0.
- Tables, by index 0..5:
  - 120°: 001,011,010,110,100,101.
  - 60°: 000,001,011,111,110,100.
  - Invalid code: 000 in 120° mode, 010 in 60° mode.
- IDLE:
  - simulated_hall and step_index hold; strobe=0; at_speed=0; timer=0; current_period=START_PERIOD.
  - On an edge with enable_sim=1: go to RUN; simulated_hall<=table[spacing][step_index]; strobe starts; timer<=0.
- RUN:
  - timer increments each cycle.
  - Step boundary is the edge where timer==current_period-1. At the boundary:
    - timer<=0.
    - step_index advances: +1 mod 6 if forward, -1 mod 6 if reverse, using sim_direction and spacing_60 sampled at that edge.
    - simulated_hall<=table[new index], or the invalid code if fault_pending; fault_pending then clears.
    - strobe restarts.
  - Each code is therefore held exactly current_period cycles.
- Ramp, applied at each boundary to the period of the next step. Let T = target clamped to >= 2.
  - If ramp_step=0: current_period<=T.
  - If current_period>T: current_period<=max(current_period-ramp_step, T).
  - If current_period<T: current_period<=min(current_period+ramp_step, T).
  - Arithmetic uses PERIOD_WIDTH+1 bits so no wrap occurs.
- Mid-step target changes affect only the next boundary.
- at_speed is a registered value of (state==RUN && current_period==T).
- Strobe:
  - High for exactly strobe_pulse_duration cycles from the cycle the code changes.
  - If duration >= current_period, the strobe is truncated and restarted at the next boundary, so it may stay continuously high.
  - A duration of 0 keeps the strobe low.
- Fault:
  - fault_inject pulse sets fault_pending; multiple pulses before a boundary count as one.
  - During a faulted step the index still advances normally, so the sequence resumes on the correct code afterwards.
  - fault_inject asserted on a boundary edge applies to the following boundary.
- erev_count increments when the index wraps: 5->0 in forward, 0->5 in reverse. It wraps at 16 bits.
- enable_sim low in RUN: next edge enters IDLE immediately, mid-step. The code holds, the strobe is cleared and fault_pending is kept.
- Reset mid-operation overrides everything asynchronously.

Test Plan:
- Forward 120°: START_PERIOD=10, target=10, ramp=0 -> codes 001,011,010,110,100,101,001 each held 10 cycles; at_speed=1 from first step; erev_count=1 after 6 steps.
- Reverse 60° at period 8: switch sim_direction mid-step -> switch takes effect at next boundary; index steps downward; codes 100,110,111,... follow; erev_count increments on 0->5.
- Ramp: START_PERIOD=100, target=40, ramp=20 -> step lengths 100,80,60,40,40; at_speed rises with the first 40-cycle step. Then target=70 -> lengths 60,70.
- Fault: fault_inject pulse during step index 2, 120° -> step 3 outputs 000 for one period; step 4 outputs 100; strobe still fires on the 000 step.
- Strobe: duration 3 with period 10 -> 3 high, 7 low per step. Duration 15 -> strobe continuously high. Duration 0 -> strobe never high.
- Disable/reset: enable low at timer=4 -> code holds and strobe=0. Re-enable -> full START_PERIOD step with the same index. reset_n low mid-step -> all outputs at reset values immediately.
